config_chain_loader: RTL and testbench

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_chain_loader.sv | 107 ++++++++++
 tb/tb_config_chain_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Serialises a word-wide configuration bitstream into a single-bit DFF chain,
// LSB first, truncating the final word so exactly CHAIN_LEN bits are shifted.
module config_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              CHAIN_HEAD,
  output logic              CHAIN_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [CNT_W-1:0]  BIT_COUNT
);

  localparam int WC_W = $clog2(WORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [WORD_W-1:0] sreg;
  logic [WC_W-1:0]   word_left;
  logic [CNT_W-1:0]  bit_count;
  logic              error_q;

  logic [CNT_W-1:0]  bit_count_nxt;
  logic              last_bit;
  logic              word_last;
  logic              in_ready;

  // Bits taken from a freshly loaded word: a whole word, or whatever the chain still needs.
  function automatic logic [WC_W-1:0] word_bits(input logic [CNT_W-1:0] done_bits);
    int rem;
    rem = CHAIN_LEN - int'(done_bits);
    return (rem >= WORD_W) ? WC_W'(WORD_W) : WC_W'(rem);
  endfunction

  assign bit_count_nxt = bit_count + CNT_W'(1);
  assign last_bit      = (bit_count_nxt == CNT_W'(CHAIN_LEN));
  assign word_last     = (word_left == WC_W'(1));

  // Ready depends only on registered state, so IN_VALID never reaches IN_READY.
  assign in_ready = (state == S_WAIT) ||
                    ((state == S_SHIFT) && word_last && !last_bit);

  assign IN_READY   = in_ready;
  assign CHAIN_EN   = (state == S_SHIFT);
  assign CHAIN_HEAD = (state == S_SHIFT) ? sreg[0] : 1'b0;
  assign BUSY       = (state == S_WAIT) || (state == S_SHIFT);
  assign DONE       = (state == S_DONE);
  assign ERROR      = error_q;
  assign BIT_COUNT  = bit_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      sreg      <= '0;
      word_left <= '0;
      bit_count <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= START && BUSY;
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state     <= S_WAIT;
            bit_count <= '0;
          end
        end
        S_WAIT: begin
          if (IN_VALID) begin
            sreg      <= IN_DATA;
            word_left <= word_bits(bit_count);
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bit_count <= bit_count_nxt;
          sreg      <= sreg >> 1;
          word_left <= word_left - WC_W'(1);
          if (last_bit) begin
            state <= S_DONE;
          end else if (word_last) begin
            // Loading in the last shift cycle keeps CHAIN_EN high across the word boundary.
            if (IN_VALID) begin
              sreg      <= IN_DATA;
              word_left <= word_bits(bit_count_nxt);
            end else begin
              state <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Drives a 20-bit and a 16-bit chain loader from one shared stimulus stream and
// scores each against a bit-stream model built from the words it accepted.
module tb_config_chain_loader;

  logic       CLK = 1'b0;
  logic       RESET, START, IN_VALID;
  logic [7:0] IN_DATA;

  logic [1:0] rdy, head, en, busy, done, err;
  logic [4:0] bc [2];

  always #5 CLK = ~CLK;

  config_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut20 (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(rdy[0]), .CHAIN_HEAD(head[0]), .CHAIN_EN(en[0]), .BUSY(busy[0]),
    .DONE(done[0]), .ERROR(err[0]), .BIT_COUNT(bc[0])
  );

  config_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(rdy[1]), .CHAIN_HEAD(head[1]), .CHAIN_EN(en[1]), .BUSY(busy[1]),
    .DONE(done[1]), .ERROR(err[1]), .BIT_COUNT(bc[1])
  );

  int passes = 0;
  int total  = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    else passes++;
  endtask

  // Reference model: pass phase (0 idle, 1 busy, 2 done) and the accepted words.
  int         phase [2];
  int         ncap [2];
  int         nw [2];
  int         c0 [2];
  int         gap [2];
  int         errobs [2];
  bit         nostall [2];
  bit         err_exp [2];
  bit         armed = 1'b0;
  logic [7:0] words [2][4];
  logic [31:0] cap [2];
  int         cyc = 0;

  always @(negedge CLK) begin
    int len;
    int pre;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      len = (d == 0) ? 20 : 16;
      if (armed) begin
        check("busy", int'(busy[d]), int'(phase[d] == 1));
        check("done", int'(done[d]), int'(phase[d] == 2));
        check("error", int'(err[d]), int'(err_exp[d]));
        check("bitcnt", int'(bc[d]), ncap[d]);
        if (!en[d]) check("head_idle0", int'(head[d]), 0);
        if (phase[d] != 1) begin
          check("en_notbusy", int'(en[d]), 0);
          check("rdy_notbusy", int'(rdy[d]), 0);
        end else if (!en[d]) begin
          check("rdy_wait", int'(rdy[d]), 1);
        end
        if (en[d] && ncap[d] == len - 1) check("rdy_last", int'(rdy[d]), 0);
      end
      if (RESET) begin
        phase[d] = 0; ncap[d] = 0; nw[d] = 0; err_exp[d] = 1'b0;
        cap[d] = '0; gap[d] = 0; errobs[d] = 0; nostall[d] = 1'b0;
      end else if (armed) begin
        pre = phase[d];
        if (err[d]) errobs[d]++;
        err_exp[d] = START && (pre == 1);
        if (pre == 1 && en[d]) begin
          if (ncap[d] / 8 < nw[d]) check("head", int'(head[d]), int'(words[d][ncap[d] / 8][ncap[d] % 8]));
          else check("underrun", 1, 0);
          cap[d][ncap[d]] = head[d];
          ncap[d]++;
          if (ncap[d] == len) begin
            phase[d] = 2;
            check("xfers", nw[d], (len + 7) / 8);
            if (nostall[d]) check("latency", cyc + 1 - c0[d], len + 2);
          end
        end
        if (pre == 1 && rdy[d] && IN_VALID && nw[d] < 4) begin
          words[d][nw[d]] = IN_DATA;
          nw[d]++;
        end
        if (pre == 1 && !IN_VALID) nostall[d] = 1'b0;
        if (pre == 1 && !en[d] && ncap[d] > 0) gap[d]++;
        if (START && pre != 1) begin
          phase[d] = 1; ncap[d] = 0; nw[d] = 0; c0[d] = cyc;
          nostall[d] = 1'b1; gap[d] = 0; errobs[d] = 0; cap[d] = '0;
        end
      end
    end
    if (RESET) armed = 1'b1;
  end

  logic [7:0] fx [3];
  bit         fixed_mode = 1'b0;
  int         widx = 0;

  // One clock; a word accepted by the 20-bit loader advances the shared data stream.
  task automatic tick();
    bit x;
    x = rdy[0] && IN_VALID;
    @(posedge CLK);
    #1;
    if (x) begin
      widx++;
      IN_DATA = (fixed_mode && widx < 3) ? fx[widx] : 8'($urandom);
    end
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300 && !(done[0] && done[1]); i++) tick();
    check("done_timeout", int'(done[0] && done[1]), 1);
  endtask

  task automatic wait_bc(input int v);
    int i;
    for (i = 0; i < 100 && int'(bc[0]) != v; i++) tick();
    check("bc_timeout", int'(bc[0]), v);
  endtask

  initial begin
    fx[0] = 8'hA5; fx[1] = 8'h3C; fx[2] = 8'hFF;
    RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00;
    repeat (3) tick();
    RESET = 1'b0;
    tick();

    // Fixed words, valid held high
    fixed_mode = 1'b1; widx = 0; IN_DATA = fx[0]; IN_VALID = 1'b1;
    START = 1'b1; tick(); START = 1'b0;
    wait_done();
    check("stream20", int'(cap[0][19:0]), 32'h000F3CA5);
    check("stream16", int'(cap[1][15:0]), 32'h00003CA5);
    fixed_mode = 1'b0;
    tick();

    // Five-cycle stall after the first word
    START = 1'b1; tick(); START = 1'b0;
    tick();
    IN_VALID = 1'b0;
    wait_bc(8);
    repeat (4) tick();
    check("hold8", int'(bc[0]), 8);
    check("stall_en", int'(en[0]), 0);
    IN_VALID = 1'b1;
    wait_done();
    check("gap20", gap[0], 5);
    check("total20", ncap[0], 20);

    // Illegal START during SHIFT
    START = 1'b1; tick(); START = 1'b0;
    wait_bc(4);
    START = 1'b1; tick(); START = 1'b0;
    wait_done();
    check("err_pulses", errobs[0], 1);

    // Reset mid-pass
    START = 1'b1; tick(); START = 1'b0;
    wait_bc(11);
    RESET = 1'b1; tick(); RESET = 1'b0;
    check("rst_outs", int'({busy[0], done[0], en[0], rdy[0], head[0], err[0]}), 0);
    check("rst_bc", int'(bc[0]), 0);
    tick();
    START = 1'b1; tick(); START = 1'b0;
    wait_done();
    check("post_rst_total", ncap[0], 20);

    // Randomized passes restarted from DONE, with random valid gaps and stray STARTs
    for (int p = 0; p < 6; p++) begin
      START = 1'b1; tick(); START = 1'b0;
      check("restart_bc", int'(bc[0]), 0);
      check("restart_done", int'(done[0]), 0);
      for (int i = 0; i < 300 && !(done[0] && done[1]); i++) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        START = busy[0] && busy[1] && ($urandom_range(0, 15) == 0);
        tick();
      end
      START = 1'b0;
      IN_VALID = 1'b1;
      wait_done();
      tick();
    end

    tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
